// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings, state codes and bus types for the byte-serial RAM arbiter
package mem_arbiter_pkg;

  localparam int RAM_ADDR_W  = 32;
  localparam int BYTE_W      = 8;
  localparam int ARB_STATE_W = 2;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [BYTE_W-1:0]     byte_t;

  // Size code 11 is treated as a full word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_SIZE_BYTE: return 3'd1;
      MEM_SIZE_HALF: return 3'd2;
      MEM_SIZE_WORD: return 3'd4;
      default:       return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester (IF/MEM), byte RAM and stall-request bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  logic              if_stall_req;
  logic              mem_stall_req;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           if_stall_req, mem_stall_req
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           if_stall_req, mem_stall_req
  );
endinterface

// File: rtl/mem_arbiter_lane.sv
// rtl/mem_arbiter_lane.sv - counter-indexed byte extract (store path) and byte insert (load path)
module mem_arbiter_lane
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  rd_sel,
  output byte_t       byte_out,
  input  logic [31:0] acc,
  input  logic [1:0]  wr_sel,
  input  byte_t       din,
  output logic [31:0] acc_next
);

  always_comb begin
    byte_out = word[{rd_sel, 3'b000} +: 8];
    acc_next = acc;
    acc_next[{wr_sel, 3'b000} +: 8] = din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-wide RAM port between IF and MEM, serialising little-endian accesses
// Optional MEM_ARB_RR_EN: round-robin tie-break using a last-owner bit; otherwise MEM always beats IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);

  arb_state_t        state;
  owner_t            owner;
  logic [ADDR_W-1:0] base;
  logic [2:0]        len;
  logic [2:0]        cnt;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] acc;

  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;

  logic [2:0]        cnt_inc;
  logic [1:0]        lane_wr;
  byte_t             next_byte;
  logic [31:0]       acc_next;

  logic              grant_mem;
  logic [ADDR_W-1:0] gnt_addr;
  logic [1:0]        gnt_size;
  logic              gnt_we;

  assign cnt_inc = cnt + 3'd1;
  // Capture in BUSY cycle cnt+1 lands the byte addressed one cycle earlier.
  assign lane_wr = cnt[1:0] - 2'd1;

  mem_arbiter_lane u_lane (
    .word     (wdata),
    .rd_sel   (cnt_inc[1:0]),
    .byte_out (next_byte),
    .acc      (acc),
    .wr_sel   (lane_wr),
    .din      (bus.ram_din),
    .acc_next (acc_next)
  );

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
  assign grant_mem = bus.mem_req & (~bus.if_req | (last_owner == OWNER_IF));
`else
  assign grant_mem = bus.mem_req;
`endif

  assign gnt_addr = grant_mem ? bus.mem_addr : bus.if_addr;
  assign gnt_size = grant_mem ? bus.mem_size : MEM_SIZE_WORD;
  assign gnt_we   = grant_mem & bus.mem_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      owner       <= OWNER_IF;
      base        <= '0;
      len         <= '0;
      cnt         <= '0;
      we          <= 1'b0;
      wdata       <= '0;
      acc         <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner  <= OWNER_IF;
`endif
    end else if (rdy) begin
      case (state)
        ARB_IDLE: begin
          if (bus.if_req | bus.mem_req) begin
            state      <= ARB_BUSY;
            owner      <= grant_mem ? OWNER_MEM : OWNER_IF;
            base       <= gnt_addr;
            len        <= size_to_len(gnt_size);
            we         <= gnt_we;
            wdata      <= bus.mem_wdata;
            cnt        <= '0;
            acc        <= '0;
            ram_a_q    <= gnt_addr;
            ram_wr_q   <= gnt_we;
            ram_dout_q <= gnt_we ? bus.mem_wdata[7:0] : 8'h00;
          end
        end
        ARB_BUSY: begin
          if (we) begin
            if (cnt_inc == len) begin
              state      <= ARB_DONE;
              ram_a_q    <= '0;
              ram_wr_q   <= 1'b0;
              ram_dout_q <= '0;
              if (owner == OWNER_MEM) mem_done_q <= 1'b1;
              else                    if_done_q  <= 1'b1;
            end else begin
              cnt        <= cnt_inc;
              ram_a_q    <= base + ADDR_W'(cnt_inc);
              ram_dout_q <= next_byte;
            end
          end else begin
            if (cnt == len) begin
              state <= ARB_DONE;
              if (owner == OWNER_MEM) begin
                mem_done_q  <= 1'b1;
                mem_rdata_q <= acc_next;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= acc_next;
              end
            end else begin
              cnt <= cnt_inc;
              if (cnt != 3'd0) acc <= acc_next;
              ram_a_q <= (cnt_inc == len) ? '0 : base + ADDR_W'(cnt_inc);
            end
          end
        end
        ARB_DONE: begin
          state      <= ARB_IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
          last_owner <= owner;
`endif
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ram_a         = ram_a_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q & rdy;
  assign bus.if_done       = if_done_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.if_data       = if_data_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.if_stall_req  = bus.if_req & ~if_done_q;
  assign bus.mem_stall_req = bus.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a byte-array reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  logic [7:0] ram_mem [0:65535];
  logic [7:0] model   [0:65535];
  bit         ram_ready;

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM stalls with rdy, so ram_din holds while rdy is low.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= pat(32'(i));
      ram_ready <= 1'b1;
    end else if (rdy) begin
      if (bus.ram_wr) ram_mem[bus.ram_a[15:0]] <= bus.ram_dout;
      bus.ram_din <= ram_mem[bus.ram_a[15:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int len_of(input logic [1:0] s);
    return (s == MEM_SIZE_BYTE) ? 1 : (s == MEM_SIZE_HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ai;
    r = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = model[ai[15:0]];
    end
    return r;
  endfunction

  // One access from IDLE; stall_len rdy-low cycles inserted at effective cycle stall_at.
  task automatic run_access(input bit is_mem, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int stall_at, input int stall_len);
    int n = is_mem ? len_of(size) : 4;
    int lat = we ? n + 1 : n + 2;
    int eff = 0;
    int held = 0;
    bit fin = 0;
    logic [31:0] exp = we ? 32'h0 : model_read(addr, n);
    logic [31:0] ai;
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = size;
      bus.mem_addr = addr; bus.mem_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int t = 0; t < lat + stall_len + 4 && !fin; t++) begin
      rdy = !(eff == stall_at && held < stall_len && eff < lat);
      #1;
      if (eff >= 1 && eff <= n) begin
        chk("ram_a", bus.ram_a, addr + 32'(eff - 1));
        chk("ram_wr", 32'(bus.ram_wr), 32'(we & rdy));
        if (we) chk("ram_dout", 32'(bus.ram_dout), 32'(wdata[8*(eff-1) +: 8]));
      end
      chk("owner_done", 32'(is_mem ? bus.mem_done : bus.if_done), 32'(eff == lat));
      if (eff == lat) begin
        chk("other_done", 32'(is_mem ? bus.if_done : bus.mem_done), 32'h0);
        if (!we) chk("read_data", is_mem ? bus.mem_rdata : bus.if_data, exp);
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        fin = 1'b1;
      end
      @(negedge clk);
      if (rdy) eff++; else held++;
    end
    chk("done_seen", 32'(fin), 32'h1);
    bus.mem_req = 1'b0;
    bus.if_req  = 1'b0;
    rdy = 1'b1;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ai = addr + 32'(i);
        model[ai[15:0]] = wdata[8*i +: 8];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          m, w;
    logic [1:0]  s;
    logic [31:0] a, d;
    int          n_r, sa, sl;
    total = 0; bad = 0; rst = 1'b0; rdy = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_size = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    for (int i = 0; i < 65536; i++) model[i] = pat(32'(i));
    repeat (3) @(negedge clk);

    chk("rst_if_done", 32'(bus.if_done), 32'h0);
    chk("rst_mem_done", 32'(bus.mem_done), 32'h0);
    chk("rst_if_data", bus.if_data, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    chk("rst_ram_a", bus.ram_a, 32'h0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
    rst = 1'b1; rdy = 1'b1;
    @(negedge clk);

    // Word store then fetch of the same bytes.
    run_access(1'b1, 1'b1, MEM_SIZE_WORD, 32'h1000, 32'h44332211, -1, 0);
    run_access(1'b0, 1'b0, MEM_SIZE_WORD, 32'h1000, 32'h0, -1, 0);
    chk("fetch_word", bus.if_data, 32'h44332211);

    // Misaligned half store and readback.
    run_access(1'b1, 1'b1, MEM_SIZE_HALF, 32'h2001, 32'hAABBCCDD, -1, 0);
    run_access(1'b1, 1'b0, MEM_SIZE_HALF, 32'h2001, 32'h0, -1, 0);
    chk("load_half", bus.mem_rdata, 32'h0000CCDD);

    // Contention: MEM byte load wins, IF fetch follows.
    run_access(1'b1, 1'b1, MEM_SIZE_BYTE, 32'h3000, 32'h00000080, -1, 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = MEM_SIZE_BYTE; bus.mem_addr = 32'h3000;
    for (int c = 0; c <= 10; c++) begin
      #1;
      chk("ct_if_stall", 32'(bus.if_stall_req), 32'(c < 10));
      chk("ct_mem_stall", 32'(bus.mem_stall_req), 32'(c < 3));
      chk("ct_mem_done", 32'(bus.mem_done), 32'(c == 3));
      chk("ct_if_done", 32'(bus.if_done), 32'(c == 10));
      if (c == 3) begin
        chk("ct_mem_rdata", bus.mem_rdata, 32'h00000080);
        bus.mem_req = 1'b0;
      end
      if (c == 10) begin
        chk("ct_if_data", bus.if_data, 32'h44332211);
        bus.if_req = 1'b0;
      end
      @(negedge clk);
    end

    // Three rdy-low cycles in the middle of a word fetch.
    run_access(1'b0, 1'b0, MEM_SIZE_WORD, 32'h1000, 32'h0, 2, 3);
    chk("stall_data", bus.if_data, 32'h44332211);

    // Asynchronous reset in cycle 3 of a word store.
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = MEM_SIZE_WORD;
    bus.mem_addr = 32'h5000; bus.mem_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("ar_ram_a", bus.ram_a, 32'h0);
    chk("ar_ram_dout", 32'(bus.ram_dout), 32'h0);
    chk("ar_mem_done", 32'(bus.mem_done), 32'h0);
    chk("ar_if_data", bus.if_data, 32'h0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("ar_no_done", 32'(bus.mem_done | bus.if_done), 32'h0);
      @(negedge clk);
    end
    run_access(1'b1, 1'b0, MEM_SIZE_WORD, 32'h1000, 32'h0, -1, 0);

    // Randomized traffic, including address wrap past 0xFFFFFFFF.
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(0, 1));
      w = m & 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h4000 + 32'($urandom_range(0, 15));
      d = $urandom;
      n_r = m ? len_of(s) : 4;
      if ($urandom_range(0, 3) == 0) begin
        sa = int'($urandom_range(1, n_r));
        sl = int'($urandom_range(1, 3));
      end else begin
        sa = -1;
        sl = 0;
      end
      run_access(m, w, s, a, d, sa, sl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
